// File: rtl/xc_sha3_lane_seq.sv
// Keccak lane-address sequencer: streams the 25 lane byte addresses of one state pass.
// Define XC_SHA3_SEQ_YX_EN to make mode 4 (yx / pi-permutation index) legal.
module xc_sha3_lane_seq #(
   parameter int XLEN = 32
) (
   input  logic            g_clk,
   input  logic            g_reset,
   input  logic            start,
   input  logic [2:0]      mode,
   input  logic [1:0]      shamt,
   input  logic [XLEN-1:0] base,
   input  logic            abort,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_addr,
   output logic [2:0]      out_x,
   output logic [2:0]      out_y,
   output logic            out_last,
   output logic            busy,
   output logic            done,
   output logic            err
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t            state_q, state_d;
   logic [2:0]        x_q, x_d, y_q, y_d, mode_q, mode_d;
   logic [1:0]        shamt_q, shamt_d;
   logic [XLEN-1:0]   base_q, base_d;
   logic              done_q, done_d, err_q, err_d;
   logic              mode_legal, last_lane, beat;
   logic [2:0]        x_rot;
   logic [4:0]        idx;
   logic [7:0]        offset;

`ifdef XC_SHA3_SEQ_YX_EN
   function automatic logic [2:0] mod5(input logic [4:0] v);
      logic [4:0] r;
      r = v;
      if (r >= 5'd20) r = r - 5'd20;
      if (r >= 5'd10) r = r - 5'd10;
      if (r >= 5'd5)  r = r - 5'd5;
      return r[2:0];
   endfunction
   assign mode_legal = (mode <= 3'd4);
`else
   assign mode_legal = (mode <= 3'd3);
`endif

   assign last_lane = (x_q == 3'd4) && (y_q == 3'd4);
   assign beat      = (state_q == RUN) && out_ready;

   always_ff @(posedge g_clk) begin
      if (g_reset) begin
         state_q <= IDLE;
         x_q     <= '0;
         y_q     <= '0;
         mode_q  <= '0;
         shamt_q <= '0;
         base_q  <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         mode_q  <= mode_d;
         shamt_q <= shamt_d;
         base_q  <= base_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   // Abort beats everything in RUN, including the final beat, so done never follows an abort.
   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      mode_d  = mode_q;
      shamt_d = shamt_q;
      base_d  = base_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (mode_legal) begin
                  mode_d  = mode;
                  shamt_d = shamt;
                  base_d  = base;
                  x_d     = '0;
                  y_d     = '0;
                  state_d = RUN;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         RUN: begin
            if (abort) begin
               state_d = IDLE;
               x_d     = '0;
               y_d     = '0;
            end else if (beat) begin
               if (last_lane) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
                  x_d     = '0;
                  y_d     = '0;
               end else if (x_q == 3'd4) begin
                  x_d = '0;
                  y_d = y_q + 3'd1;
               end else begin
                  x_d = x_q + 3'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Lane index from the captured mode; the x rotations avoid a general modulo.
   always_comb begin
      x_rot = x_q;
      case (mode_q)
         3'd1:    x_rot = (x_q == 3'd4) ? 3'd0 : x_q + 3'd1;
         3'd2:    x_rot = (x_q >= 3'd3) ? x_q - 3'd3 : x_q + 3'd2;
         3'd3:    x_rot = (x_q == 3'd0) ? 3'd4 : x_q - 3'd1;
         default: x_rot = x_q;
      endcase
      idx = 5'(x_rot) + 5'(y_q) * 5'd5;
`ifdef XC_SHA3_SEQ_YX_EN
      if (mode_q == 3'd4)
         idx = 5'(y_q) + 5'(mod5(5'(x_q) * 5'd2 + 5'(y_q) * 5'd3)) * 5'd5;
`endif
   end

   assign offset    = 8'(idx) << shamt_q;
   assign out_valid = (state_q == RUN);
   assign busy      = (state_q == RUN);
   assign out_addr  = busy ? (base_q + {{(XLEN-8){1'b0}}, offset}) : '0;
   assign out_x     = x_q;
   assign out_y     = y_q;
   assign out_last  = busy && last_lane;
   assign done      = done_q;
   assign err       = err_q;

endmodule

// File: doc/xc_sha3_lane_seq.md
# xc_sha3_lane_seq

Lane-address sequencer for the XCrypto SHA3 index datapath. Walks all 25 Keccak lane coordinates (x,y) in a fixed order and, for each, computes the lane byte address using the same index functions as the xc.sha3.{xy,x1,x2,x4,yx} instructions. It streams one address per beat over a valid/ready handshake. It sits between a Keccak-f round controller (or DMA-style load/store engine) and the memory request port, replacing 25 software index instructions per state pass.

## Interface
Parameters:
- XLEN, 32, address width.

Ports:
- g_clk  in  1  clock; all state changes on the rising edge.
- g_reset  in  1  synchronous, active-high reset.
- start  in  1  begin a 25-lane pass; sampled only in IDLE.
- mode  in  3  index function: 0=xy, 1=x1, 2=x2, 3=x4, 4=yx, 5..7 illegal.
- shamt  in  2  post-shift applied to the lane index (same meaning as the instruction shamt field).
- base  in  XLEN  state base byte address.
- abort  in  1  cancel an active pass.
- out_valid  out  1  address beat valid.
- out_ready  in  1  consumer accepts the beat.
- out_addr  out  XLEN  lane byte address.
- out_x  out  3  current x (0..4).
- out_y  out  3  current y (0..4).
- out_last  out  1  current beat is lane (4,4).
- busy  out  1  state is RUN.
- done  out  1  one-cycle pulse after the final beat is accepted.
- err  out  1  one-cycle pulse when start is rejected.

## Operation
- States: IDLE, RUN.
- In IDLE with start=1 and a legal mode, capture mode, shamt and base. Set x=0 and y=0, then go to RUN.
- In IDLE with start=1 and an illegal mode, stay in IDLE and pulse err the next cycle.
- Order: x is the inner loop and y the outer loop: (0,0),(1,0)..(4,0),(0,1)..(4,4).
- Lane index idx:
  - xy: x + 5*y
  - x1: ((x+1)%5) + 5*y
  - x2: ((x+2)%5) + 5*y
  - x4: ((x+4)%5) + 5*y
  - yx: y + 5*((2x+3y)%5)
- offset = idx << shamt, 8 bits, zero-extended.
- out_addr = captured base + offset, modulo 2^XLEN (wraps, no error).
- On a beat (out_valid & out_ready):
  - If x<4, increment x.
  - Otherwise set x=0 and increment y.
  - On the (4,4) beat, go to IDLE and pulse done.
- All out_* signals are registered, or derived combinationally from registered state only. No combinational path from out_ready to out_valid.
- Captured mode, shamt and base are stable for the whole pass. Input changes during RUN are ignored.
- start in RUN is ignored (no err).
- abort in RUN: go to IDLE next cycle, no done, no further beats. If abort coincides with a beat, that beat counts as accepted and still no more are issued. This holds even on the last beat: abort wins, done is not pulsed.
- abort in IDLE is ignored. start and abort together in IDLE: start is processed.

## Timing
- Reset values: out_valid=0, out_addr=0, out_x=0, out_y=0, out_last=0, busy=0, done=0, err=0, state=IDLE.
- Reset mid-pass: pass discarded. No done, outputs at reset values next cycle.
- Start accepted at edge N: out_valid=1 and busy=1 from cycle N+1, showing (0,0).
- With out_ready held high: 25 beats, one per cycle, N+1..N+25. done=1 and busy=0 in cycle N+26.
- With out_ready=0: out_valid, out_addr, out_x, out_y and out_last are held unchanged.
- A new start is accepted in the same cycle done is high. Back-to-back passes have one idle cycle between them.
- err is high for exactly one cycle, the cycle after the rejected start.

## Configuration
- XC_SHA3_SEQ_YX_EN:
  - Defined: mode 4 (yx, the Keccak pi permutation index) is legal.
  - Undefined: mode 4 is illegal (err pulse, no pass) and the yx index logic is not synthesised.

## Test plan
- mode=0, shamt=3, base=0x1000, out_ready=1. Addresses in order: beat 1 0x1000, beat 2 0x1008, beat 6 (0,1) 0x1028, beat 25 (4,4) 0x10C0 with out_last=1. done at N+26.
- mode=1, shamt=3, base=0x1000. Beat 1 = 0x1008, beat 5 (x=4) = 0x1000.
- mode=4 with XC_SHA3_SEQ_YX_EN, shamt=0, base=0. Beat 2 (1,0) = 0x0A, beat 7 (1,1) = 0x01.
- mode=4 without the macro: no beats, err=1 for one cycle, busy stays 0.
- Backpressure: out_ready=0 for 3 cycles on beat 6. out_addr is held at 0x1028, and the pass still yields exactly 25 distinct beats.
- abort asserted while beat 10 is accepted. out_valid=0 the next cycle, no done. A following start=1 with base=0x2000 yields first addr 0x2000.
